exec_stage: RTL and testbench

- Execute/write-back stage directly downstream of the 32x16 register file.
- Captures the issued instruction and consumes Rsrc1/Rsrc2, which the register file presents one cycle after the addresses. Computes a 16-bit result and drives Rdst/Rdst_addr/Rwrite back into the register file write port.
- Provides operand forwarding to cover register-file write latency, plus a 16-cycle shift-add multiplier with stall back-pressure to decode.

---
 rtl/exec_stage.sv | 210 +++++++++++++++++++++
 tb/tb_exec_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - execute/write-back stage with two-deep operand forwarding
// and a stalling shift-add multiplier feeding the register file write port.
module exec_stage #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  logic [3:0]        opcode,
   input  logic [ADDR_W-1:0] Rsrc1_addr,
   input  logic [ADDR_W-1:0] Rsrc2_addr,
   input  logic [ADDR_W-1:0] Rdst_addr_in,
   input  logic [DATA_W-1:0] Rsrc1,
   input  logic [DATA_W-1:0] Rsrc2,
   output logic              stall,
   output logic [DATA_W-1:0] Rdst,
   output logic [ADDR_W-1:0] Rdst_addr,
   output logic              Rwrite
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam int SH_W  = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_SLT = 4'd8;
   localparam logic [3:0] OP_MOV = 4'd9;
   localparam logic [3:0] OP_MUL = 4'd10;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t              state_q, state_d;

   logic                e_valid_q, e_valid_d;
   logic [3:0]          e_op_q, e_op_d;
   logic [ADDR_W-1:0]   e_src1_q, e_src1_d;
   logic [ADDR_W-1:0]   e_src2_q, e_src2_d;
   logic [ADDR_W-1:0]   e_dst_q, e_dst_d;

   logic                rwrite_q, rwrite_d;
   logic [DATA_W-1:0]   rdst_q, rdst_d;
   logic [ADDR_W-1:0]   rdst_addr_q, rdst_addr_d;

   logic                pw_valid_q;
   logic [ADDR_W-1:0]   pw_addr_q;
   logic [DATA_W-1:0]   pw_data_q;

   logic [DATA_W-1:0]   mcand_q, mcand_d;
   logic [DATA_W-1:0]   mplier_q, mplier_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   mdst_q, mdst_d;

   logic [DATA_W-1:0]   op_a, op_b, alu_res, acc_sum;
   logic                alu_wr, mul_start, mul_done;

   // Forwarding: the current write-back wins over the previous-cycle write,
   // which wins over register file data.
   always_comb begin
      op_a = Rsrc1;
      if (pw_valid_q && (pw_addr_q == e_src1_q)) op_a = pw_data_q;
      if (rwrite_q && (rdst_addr_q == e_src1_q)) op_a = rdst_q;
      op_b = Rsrc2;
      if (pw_valid_q && (pw_addr_q == e_src2_q)) op_b = pw_data_q;
      if (rwrite_q && (rdst_addr_q == e_src2_q)) op_b = rdst_q;
   end

   always_comb begin
      alu_res = '0;
      case (e_op_q)
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_NOT:  alu_res = ~op_a;
         OP_SHL:  alu_res = op_a << op_b[SH_W-1:0];
         OP_SHR:  alu_res = op_a >> op_b[SH_W-1:0];
         OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_MOV:  alu_res = op_a;
         default: alu_res = '0;
      endcase
   end

   assign alu_wr  = e_valid_q && (e_op_q <= OP_MOV);
   assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (mul_start) state_d = S_MUL;
         S_MUL:   if (mul_done)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs; stall depends on registered state only
   always_comb begin
      mul_start = e_valid_q && (e_op_q == OP_MUL) && (state_q == S_IDLE);
      mul_done  = (state_q == S_MUL) && (cnt_q == CNT_LAST);
      stall     = (e_valid_q && (e_op_q == OP_MUL)) || (state_q == S_MUL);
   end

   always_comb begin
      e_valid_d = issue_valid && !stall;
      e_op_d    = e_op_q;
      e_src1_d  = e_src1_q;
      e_src2_d  = e_src2_q;
      e_dst_d   = e_dst_q;
      if (e_valid_d) begin
         e_op_d   = opcode;
         e_src1_d = Rsrc1_addr;
         e_src2_d = Rsrc2_addr;
         e_dst_d  = Rdst_addr_in;
      end
   end

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      mdst_d   = mdst_q;
      if (mul_start) begin
         mcand_d  = op_a;
         mplier_d = op_b;
         acc_d    = '0;
         cnt_d    = '0;
         mdst_d   = e_dst_q;
      end else if (state_q == S_MUL) begin
         acc_d    = acc_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
      end
   end

   // Multiplier completion and single-cycle results never coincide since
   // the stall keeps the E stage empty while the multiplier runs.
   always_comb begin
      rwrite_d    = alu_wr || mul_done;
      rdst_d      = rdst_q;
      rdst_addr_d = rdst_addr_q;
      if (mul_done) begin
         rdst_d      = acc_sum;
         rdst_addr_d = mdst_q;
      end else if (alu_wr) begin
         rdst_d      = alu_res;
         rdst_addr_d = e_dst_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_valid_q   <= 1'b0;
         e_op_q      <= '0;
         e_src1_q    <= '0;
         e_src2_q    <= '0;
         e_dst_q     <= '0;
         rwrite_q    <= 1'b0;
         rdst_q      <= '0;
         rdst_addr_q <= '0;
         pw_valid_q  <= 1'b0;
         pw_addr_q   <= '0;
         pw_data_q   <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         mdst_q      <= '0;
      end else begin
         e_valid_q   <= e_valid_d;
         e_op_q      <= e_op_d;
         e_src1_q    <= e_src1_d;
         e_src2_q    <= e_src2_d;
         e_dst_q     <= e_dst_d;
         rwrite_q    <= rwrite_d;
         rdst_q      <= rdst_d;
         rdst_addr_q <= rdst_addr_d;
         pw_valid_q  <= rwrite_q;
         pw_addr_q   <= rdst_addr_q;
         pw_data_q   <= rdst_q;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         mdst_q      <= mdst_d;
      end
   end

   assign Rdst      = rdst_q;
   assign Rdst_addr = rdst_addr_q;
   assign Rwrite    = rwrite_q;

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - directed self-checking bench for exec_stage.
module tb_exec_stage;
   localparam int DW = 16;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          issue_valid;
   logic [3:0]    opcode;
   logic [AW-1:0] Rsrc1_addr, Rsrc2_addr, Rdst_addr_in;
   logic [DW-1:0] Rsrc1, Rsrc2;
   logic          stall;
   logic [DW-1:0] Rdst;
   logic [AW-1:0] Rdst_addr;
   logic          Rwrite;

   int errors = 0;
   int checks = 0;
   int pulses;

   exec_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue_valid  (issue_valid),
      .opcode       (opcode),
      .Rsrc1_addr   (Rsrc1_addr),
      .Rsrc2_addr   (Rsrc2_addr),
      .Rdst_addr_in (Rdst_addr_in),
      .Rsrc1        (Rsrc1),
      .Rsrc2        (Rsrc2),
      .stall        (stall),
      .Rdst         (Rdst),
      .Rdst_addr    (Rdst_addr),
      .Rwrite       (Rwrite)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      issue_valid  = 1'b0;
      opcode       = 4'd0;
      Rsrc1_addr   = '0;
      Rsrc2_addr   = '0;
      Rdst_addr_in = '0;
   endtask

   task automatic drive_issue(input logic [3:0] op, input logic [AW-1:0] s1,
                              input logic [AW-1:0] s2, input logic [AW-1:0] d);
      issue_valid  = 1'b1;
      opcode       = op;
      Rsrc1_addr   = s1;
      Rsrc2_addr   = s2;
      Rdst_addr_in = d;
   endtask

   // Issue one op on R20/R21 -> R10, supply operands in E, check in WB cycle.
   task automatic alu_op(input string tag, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic wr, input logic [DW-1:0] exp);
      @(negedge clk);
      drive_issue(op, 5'd20, 5'd21, 5'd10);
      @(negedge clk);
      drive_idle();
      Rsrc1 = a;
      Rsrc2 = b;
      chk({tag, "_stall"}, stall, 0);
      @(negedge clk);
      chk({tag, "_wr"}, Rwrite, wr);
      chk({tag, "_data"}, Rdst, exp);
      chk({tag, "_addr"}, Rdst_addr, 10);
   endtask

   initial begin
      // Reset with random inputs
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         issue_valid  = 1'($urandom);
         opcode       = 4'($urandom);
         Rsrc1_addr   = 5'($urandom);
         Rsrc2_addr   = 5'($urandom);
         Rdst_addr_in = 5'($urandom);
         Rsrc1        = 16'($urandom);
         Rsrc2        = 16'($urandom);
         chk("rst_wr", Rwrite, 0);
         chk("rst_data", Rdst, 0);
         chk("rst_addr", Rdst_addr, 0);
         chk("rst_stall", stall, 0);
      end
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_nowr", Rwrite, 0);
      end

      // ADD R3 = R1 + R2
      @(negedge clk);
      drive_issue(4'd0, 5'd1, 5'd2, 5'd3);
      @(negedge clk);
      drive_idle();
      Rsrc1 = 16'h0005;
      Rsrc2 = 16'h0003;
      @(negedge clk);
      chk("add_wr", Rwrite, 1);
      chk("add_addr", Rdst_addr, 3);
      chk("add_data", Rdst, 16'h0008);
      @(negedge clk);
      chk("add_wr_drop", Rwrite, 0);
      chk("add_hold", Rdst, 16'h0008);

      // Forwarding chain
      @(negedge clk);
      drive_issue(4'd0, 5'd1, 5'd2, 5'd3);
      @(negedge clk);
      drive_issue(4'd1, 5'd3, 5'd1, 5'd4);
      Rsrc1 = 16'h0005;
      Rsrc2 = 16'h0003;
      @(negedge clk);
      drive_issue(4'd3, 5'd3, 5'd0, 5'd5);
      Rsrc1 = 16'h0000;
      Rsrc2 = 16'h0005;
      chk("fw_add_wr", Rwrite, 1);
      chk("fw_add_data", Rdst, 16'h0008);
      @(negedge clk);
      drive_idle();
      Rsrc1 = 16'h0000;
      Rsrc2 = 16'h0000;
      chk("fw_sub_wr", Rwrite, 1);
      chk("fw_sub_addr", Rdst_addr, 4);
      chk("fw_sub_data", Rdst, 16'h0003);
      @(negedge clk);
      chk("fw_or_wr", Rwrite, 1);
      chk("fw_or_addr", Rdst_addr, 5);
      chk("fw_or_data", Rdst, 16'h0008);
      @(negedge clk);
      chk("fw_end_wr", Rwrite, 0);

      // MUL R6 = 0x12 * 0x34 with an ignored issue during the stall
      @(negedge clk);
      drive_issue(4'd10, 5'd1, 5'd2, 5'd6);
      @(negedge clk);
      drive_idle();
      Rsrc1 = 16'h0012;
      Rsrc2 = 16'h0034;
      chk("mul_stall_t1", stall, 1);
      for (int k = 2; k <= 17; k++) begin
         @(negedge clk);
         if (k == 5) drive_issue(4'd0, 5'd1, 5'd2, 5'd7);
         else drive_idle();
         Rsrc1 = 16'h1111;
         Rsrc2 = 16'h2222;
         chk($sformatf("mul_stall_t%0d", k), stall, 1);
         chk($sformatf("mul_nowr_t%0d", k), Rwrite, 0);
      end
      @(negedge clk);
      chk("mul_wr", Rwrite, 1);
      chk("mul_data", Rdst, 16'h03A8);
      chk("mul_addr", Rdst_addr, 6);
      chk("mul_stall_end", stall, 0);
      @(negedge clk);
      chk("mul_ignored_nowr", Rwrite, 0);
      @(negedge clk);
      chk("mul_ignored_nowr2", Rwrite, 0);

      // MUL 0x0100 * 0x0100 wraps to zero
      @(negedge clk);
      drive_issue(4'd10, 5'd1, 5'd2, 5'd8);
      @(negedge clk);
      drive_idle();
      Rsrc1 = 16'h0100;
      Rsrc2 = 16'h0100;
      repeat (17) @(negedge clk);
      chk("mul0_wr", Rwrite, 1);
      chk("mul0_data", Rdst, 16'h0000);
      chk("mul0_addr", Rdst_addr, 8);

      // Arithmetic edges
      alu_op("sub_wrap", 4'd1,  16'h0000, 16'h0001, 1'b1, 16'hFFFF);
      alu_op("slt_neg",  4'd8,  16'hFFFF, 16'h0001, 1'b1, 16'h0001);
      alu_op("slt_pos",  4'd8,  16'h0001, 16'hFFFF, 1'b1, 16'h0000);
      alu_op("shl_mask", 4'd6,  16'h0001, 16'h0011, 1'b1, 16'h0002);
      alu_op("nop13",    4'd13, 16'h1234, 16'h5678, 1'b0, 16'h0002);
      alu_op("add_wrap", 4'd0,  16'hFFFF, 16'h0002, 1'b1, 16'h0001);
      alu_op("and",      4'd2,  16'hF0F0, 16'h3C3C, 1'b1, 16'h3030);
      alu_op("xor",      4'd4,  16'hF0F0, 16'h3C3C, 1'b1, 16'hCCCC);
      alu_op("not",      4'd5,  16'h1234, 16'hFFFF, 1'b1, 16'hEDCB);
      alu_op("shr",      4'd7,  16'h8000, 16'h000F, 1'b1, 16'h0001);
      alu_op("mov",      4'd9,  16'hBEEF, 16'h0000, 1'b1, 16'hBEEF);
      alu_op("slt_eq",   4'd8,  16'h8000, 16'h8000, 1'b1, 16'h0000);

      // Reset in the middle of a multiply
      @(negedge clk);
      drive_issue(4'd10, 5'd1, 5'd2, 5'd6);
      @(negedge clk);
      drive_idle();
      Rsrc1 = 16'h0003;
      Rsrc2 = 16'h0004;
      for (int k = 2; k <= 7; k++) begin
         @(negedge clk);
         chk($sformatf("abort_stall_t%0d", k), stall, 1);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_rst_wr", Rwrite, 0);
      chk("abort_rst_stall", stall, 0);
      chk("abort_rst_data", Rdst, 0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (Rwrite) pulses++;
      end
      chk("abort_no_write", pulses, 0);
      chk("abort_stall_clear", stall, 0);

      // ADD R9 = R1 + R2 after recovery
      @(negedge clk);
      drive_issue(4'd0, 5'd1, 5'd2, 5'd9);
      @(negedge clk);
      drive_idle();
      Rsrc1 = 16'h0007;
      Rsrc2 = 16'h0008;
      @(negedge clk);
      chk("recov_wr", Rwrite, 1);
      chk("recov_addr", Rdst_addr, 9);
      chk("recov_data", Rdst, 16'h000F);
      @(negedge clk);
      chk("recov_wr_drop", Rwrite, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
